shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for one shared WIDTH-bit D-flip-flop register bank.
//  N_REQ requesters compete for write access. Each completed transaction loads one requester's data into the shared bank.
//  The block sits between the requester blocks and the storage bank. It owns the bank's load enable and clear.

---
 rtl/shared_reg_arbiter_if.sv | 41 ++++
 rtl/shared_reg_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
//   Bundles the requester-side and bank-side signals of the shared register
//   arbiter.
//   master : requester side; drives req/wdata/err_clr and observes the results.
//   slave  : arbiter side; drives gnt/owner/ack/q/busy/err.
//   Signals:
//     req     [N_REQ]        level request per requester
//     wdata   [N_REQ*WIDTH]  per-requester data, slice i = wdata[i*WIDTH +: WIDTH]
//     err_clr                synchronous clear of the sticky timeout flag
//     gnt     [N_REQ]        one-hot grant, zero when idle
//     owner   [clog2(N_REQ)] last requester that completed a load
//     ack                    one-cycle pulse when the shared register loads
//     q       [WIDTH]        shared register contents
//     busy                   arbiter is not idle
//     err                    sticky hold-timeout flag
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic                   err_clr;
  logic [N_REQ-1:0]       gnt;
  logic [IDX_W-1:0]       owner;
  logic                   ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic                   err;

  modport master (
    output req, wdata, err_clr,
    input  gnt, owner, ack, q, busy, err
  );

  modport slave (
    input  req, wdata, err_clr,
    output gnt, owner, ack, q, busy, err
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter and sequencer for one shared WIDTH-bit register bank.
//   N_REQ requesters compete for write access. Each completed transaction loads
//   the winner's data slice into the bank. A requester may hold the grant after
//   its load for at most HOLD_MAX release cycles. After that the grant is forced
//   off and the sticky err flag is set.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low; clears all state immediately
//     bus    shared_reg_arbiter_if.slave (req/wdata/err_clr in,
//            gnt/owner/ack/q/busy/err out, all outputs registered)
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);
  localparam int               IDX_W     = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [N_REQ-1:0] GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] GNT_NONE  = {N_REQ{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [N_REQ-1:0]   gnt_r, gnt_nx_s;
  logic               ack_r, ack_nx_s;
  logic [WIDTH-1:0]   q_r, q_nx_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nx_s;
  logic [IDX_W-1:0]   owner_r, owner_nx_s;
  logic [IDX_W-1:0]   win_r, win_nx_s;
  logic [7:0]         hold_r, hold_nx_s;
  logic               err_r, err_nx_s;
  logic [IDX_W-1:0]   pick_s;
  logic               pick_vld_s;
  logic [WIDTH-1:0]   win_data_s;

  // Round-robin search: first requester at or after ptr+1, wrapping.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    idx        = 0;
    cand       = ptr_r;
    pick_s     = ptr_r;
    pick_vld_s = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx  = int'(ptr_r) + i;
      idx  = (idx >= N_REQ) ? (idx - N_REQ) : idx;
      cand = IDX_W'(idx);
      if (!pick_vld_s && bus.req[cand]) begin
        pick_s     = cand;
        pick_vld_s = 1'b1;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Select the registered winner's data slice; other slices are never used.
  always_comb begin
    win_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (win_r == IDX_W'(i)) begin
        win_data_s = bus.wdata[i*WIDTH +: WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    ack_nx_s   = 1'b0;
    q_nx_s     = q_r;
    ptr_nx_s   = ptr_r;
    owner_nx_s = owner_r;
    win_nx_s   = win_r;
    hold_nx_s  = hold_r;
    // A timeout below overrides this clear, so set wins over err_clr.
    if (bus.err_clr) begin
      err_nx_s = 1'b0;
    end else begin
      err_nx_s = err_r;
    end

    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          win_nx_s   = pick_s;
          gnt_nx_s   = GNT_ONE << pick_s;
          state_nx_s = GRANT;
        end else begin
          gnt_nx_s   = GNT_NONE;
        end
      end
      GRANT: begin
        if (bus.req[win_r]) begin
          q_nx_s     = win_data_s;
          ack_nx_s   = 1'b1;
          ptr_nx_s   = win_r;
          owner_nx_s = win_r;
          state_nx_s = LOAD;
        end else begin
          // Request withdrawn before the load: abort, pointer untouched.
          gnt_nx_s   = GNT_NONE;
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        hold_nx_s = 8'd0;
        // A requester that already dropped req is released on this edge,
        // which gives the three-edge turnaround to the next grant.
        if (!bus.req[win_r]) begin
          gnt_nx_s   = GNT_NONE;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.req[win_r]) begin
          gnt_nx_s   = GNT_NONE;
          state_nx_s = IDLE;
        end else if (hold_r == HOLD_LAST) begin
          gnt_nx_s   = GNT_NONE;
          err_nx_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          hold_nx_s  = hold_r + 8'd1;
        end
      end
      default: begin
        gnt_nx_s   = GNT_NONE;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and output registers; async reset discards any load in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_r   <= GNT_NONE;
      ack_r   <= 1'b0;
      q_r     <= {WIDTH{1'b0}};
      ptr_r   <= PTR_RST;
      owner_r <= {IDX_W{1'b0}};
      win_r   <= {IDX_W{1'b0}};
      hold_r  <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      gnt_r   <= gnt_nx_s;
      ack_r   <= ack_nx_s;
      q_r     <= q_nx_s;
      ptr_r   <= ptr_nx_s;
      owner_r <= owner_nx_s;
      win_r   <= win_nx_s;
      hold_r  <= hold_nx_s;
      err_r   <= err_nx_s;
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.q     = q_r;
  assign bus.owner = owner_r;
  assign bus.err   = err_r;
  assign bus.busy  = (state_r != IDLE);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction-level view of the bank and arbitration pointer.
  int         m_ptr;
  logic [W-1:0] m_q;
  int         m_owner;
  logic       m_err;

  // Results of the last transaction and what the model predicts for it.
  logic [N-1:0] o_gnt;
  logic         o_ack0, o_ack1, o_ack2, o_busy, o_err;
  logic [W-1:0] o_q;
  logic [1:0]   o_owner;
  int           o_rel;
  int           t_k;
  logic [W-1:0] e_q;
  int           e_rel;
  logic         e_err;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] sh;
    for (int i = 1; i <= N; i++) begin
      sh = r >> ((p + i) % N);
      if (sh[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = N - 1; m_q = '0; m_owner = 0; m_err = 1'b0;
  endfunction

  // Grant must be one-hot or zero in every cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_cmp++;
      if ((bus.gnt & (bus.gnt - 4'd1)) !== 4'd0) begin
        n_bad++; $display("FAIL gnt_onehot: got %b want one-hot or zero", bus.gnt);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0; bus.req = '0; bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Drive one complete transaction from a negedge; keeps req[winner] high for
  // 'hold' cycles after ack is seen. Records observations and model predictions.
  task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] d, input int hold);
    t_k   = rr_pick(r, m_ptr);
    e_q   = W'(d >> (t_k * W));
    e_rel = ((hold < HOLD) ? hold : HOLD) + 1;
    e_err = (hold >= HOLD) ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
    bus.req = r; bus.wdata = d;
    @(negedge clk);
    o_gnt = bus.gnt; o_ack0 = bus.ack;
    @(negedge clk);
    o_ack1 = bus.ack; o_q = bus.q; o_owner = bus.owner;
    o_rel = 0; o_ack2 = 1'b0;
    while (bus.gnt !== 4'd0 && o_rel < 40) begin
      if (o_rel == hold) bus.req = bus.req & ~(4'd1 << t_k);
      @(negedge clk);
      o_rel++;
      if (o_rel == 1) o_ack2 = bus.ack;
    end
    o_busy = bus.busy; o_err = bus.err;
    bus.req = '0;
    m_ptr = t_k; m_q = e_q; m_owner = t_k; m_err = e_err;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.req = 4'hF; bus.wdata = 32'hDEAD_BEEF; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'd0)  begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.ack !== 1'b0)  begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    n_cmp++; if (bus.q !== 8'd0)    begin n_bad++; $display("FAIL reset_q: got %h want 00", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
    reset = 1'b1;
    model_reset();
    txn(4'hF, 32'h4433_2211, 0);
    n_cmp++; if (o_gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", o_gnt); end
    n_cmp++; if (o_q !== 8'h11)     begin n_bad++; $display("FAIL reset_first_q: got %h want 11", o_q); end
  endtask

  task automatic test_single();
    txn(4'b0100, 32'h11A5_2233, 0);
    n_cmp++; if (o_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", o_gnt); end
    n_cmp++; if (o_ack0 !== 1'b0)   begin n_bad++; $display("FAIL single_ack_early: got %b want 0", o_ack0); end
    n_cmp++; if (o_ack1 !== 1'b1)   begin n_bad++; $display("FAIL single_ack: got %b want 1", o_ack1); end
    n_cmp++; if (o_q !== 8'hA5)     begin n_bad++; $display("FAIL single_q: got %h want a5", o_q); end
    n_cmp++; if (o_owner !== 2'd2)  begin n_bad++; $display("FAIL single_owner: got %0d want 2", o_owner); end
    n_cmp++; if (o_rel !== 1)       begin n_bad++; $display("FAIL single_release: got %0d cycles want 1", o_rel); end
    n_cmp++; if (o_ack2 !== 1'b0)   begin n_bad++; $display("FAIL single_ack_pulse: got %b want 0", o_ack2); end
    n_cmp++; if (o_busy !== 1'b0)   begin n_bad++; $display("FAIL single_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_abort();
    bus.req = 4'b0010; bus.wdata = 32'h0000_3C00;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL abort_gnt_drop: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.ack !== 1'b0)    begin n_bad++; $display("FAIL abort_ack: got %b want 0", bus.ack); end
    n_cmp++; if (bus.q !== m_q)       begin n_bad++; $display("FAIL abort_q: got %h want %h", bus.q, m_q); end
    n_cmp++; if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    // Pointer still at 2: search 3,0,1 picks requester 1, not 2.
    txn(4'b0110, 32'h0077_6600, 0);
    n_cmp++; if (o_gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_ptr_kept: got %b want 0010", o_gnt); end
    n_cmp++; if (o_q !== 8'h66)     begin n_bad++; $display("FAIL abort_next_q: got %h want 66", o_q); end
  endtask

  task automatic test_fairness();
    logic [N*W-1:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      txn(4'hF, d, 0);
      n_cmp++; if (o_gnt !== (4'd1 << (i % 4))) begin n_bad++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, o_gnt, 4'd1 << (i % 4)); end
      n_cmp++; if (o_q !== e_q) begin n_bad++; $display("FAIL fair_q[%0d]: got %h want %h", i, o_q, e_q); end
    end
  endtask

  task automatic test_timeout();
    txn(4'b1000, 32'h5A00_0000, 40);
    n_cmp++; if (o_gnt !== 4'b1000) begin n_bad++; $display("FAIL tmo_gnt: got %b want 1000", o_gnt); end
    n_cmp++; if (o_rel !== HOLD + 1) begin n_bad++; $display("FAIL tmo_release: got %0d cycles want %0d", o_rel, HOLD + 1); end
    n_cmp++; if (o_err !== 1'b1)    begin n_bad++; $display("FAIL tmo_err: got %b want 1", o_err); end
    n_cmp++; if (o_busy !== 1'b0)   begin n_bad++; $display("FAIL tmo_busy: got %b want 0", o_busy); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b1)  begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", bus.err); end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0; m_err = 1'b0;
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL tmo_clear: got %b want 0", bus.err); end
    // Held exactly HOLD cycles: released normally, no error.
    txn(4'b1000, 32'h6B00_0000, HOLD);
    n_cmp++; if (o_rel !== HOLD + 1) begin n_bad++; $display("FAIL tmo_edge_release: got %0d want %0d", o_rel, HOLD + 1); end
    n_cmp++; if (o_err !== 1'b0)    begin n_bad++; $display("FAIL tmo_edge_err: got %b want 0", o_err); end
    // err_clr held through a timeout: the set wins on the timeout edge.
    bus.err_clr = 1'b1;
    txn(4'b1000, 32'h7C00_0000, 40);
    n_cmp++; if (o_err !== 1'b1)    begin n_bad++; $display("FAIL tmo_set_wins: got %b want 1", o_err); end
    @(negedge clk);
    bus.err_clr = 1'b0; m_err = 1'b0;
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL tmo_clear2: got %b want 0", bus.err); end
  endtask

  task automatic test_random();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    int             hold;
    for (int i = 0; i < 30; i++) begin
      r    = 4'($urandom_range(1, 15));
      d    = $urandom;
      hold = ($urandom_range(0, 7) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 3);
      bus.err_clr = ($urandom_range(0, 3) == 0);
      txn(r, d, hold);
      n_cmp++; if (o_gnt !== (4'd1 << t_k)) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, o_gnt, 4'd1 << t_k); end
      n_cmp++; if (o_ack1 !== 1'b1)   begin n_bad++; $display("FAIL rnd_ack[%0d]: got %b want 1", i, o_ack1); end
      n_cmp++; if (o_q !== e_q)       begin n_bad++; $display("FAIL rnd_q[%0d]: got %h want %h", i, o_q, e_q); end
      n_cmp++; if (o_owner !== 2'(t_k)) begin n_bad++; $display("FAIL rnd_owner[%0d]: got %0d want %0d", i, o_owner, t_k); end
      n_cmp++; if (o_rel !== e_rel)   begin n_bad++; $display("FAIL rnd_release[%0d]: got %0d want %0d", i, o_rel, e_rel); end
      n_cmp++; if (o_err !== e_err)   begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, o_err, e_err); end
    end
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset_midop();
    bus.req = 4'b0100; bus.wdata = 32'h00C3_0000;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL midop_in_load: got ack %b want 1", bus.ack); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.ack !== 1'b0)  begin n_bad++; $display("FAIL midop_ack: got %b want 0", bus.ack); end
    n_cmp++; if (bus.gnt !== 4'd0)  begin n_bad++; $display("FAIL midop_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.q !== 8'd0)    begin n_bad++; $display("FAIL midop_q: got %h want 00", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midop_busy: got %b want 0", bus.busy); end
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    txn(4'b1101, 32'h1122_3344, 0);
    n_cmp++; if (o_gnt !== 4'b0001) begin n_bad++; $display("FAIL midop_first_gnt: got %b want 0001", o_gnt); end
  endtask

  initial begin
    reset = 1'b0; bus.req = '0; bus.wdata = '0; bus.err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_abort();
    test_fairness();
    test_timeout();
    test_random();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
